pll_lock_seq: RTL and testbench



---
 rtl/npu_clk_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_seq.sv | 119 +++++++++++
 tb/tb_pll_lock_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/npu_clk_pkg.sv
// Shared clocking package: PLL supervisor state encoding and default dwell constants.
package npu_clk_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } pll_state_e;

  localparam int unsigned PLL_RST_CYCLES_DEF = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 270000;
  localparam int unsigned STABLE_CYCLES_DEF  = 2048;
  localparam int unsigned HOLD_CYCLES_DEF    = 16;
  localparam int unsigned CNT_W_DEF          = 8;

  // Largest of the four dwell lengths; sizes the shared dwell counter.
  function automatic int unsigned dwell_max(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-stage synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_seq.sv
// PLL bring-up and lock supervisor: drives PLL reset, watches lock, and releases
// the downstream system reset only after lock has been stable long enough.
module pll_lock_seq
  import npu_clk_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             clr_status,
  output logic             pll_reset,
  output logic             sys_rst,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam int unsigned MAX_DWELL = dwell_max(PLL_RST_CYCLES, TIMEOUT_CYCLES,
                                                STABLE_CYCLES, HOLD_CYCLES);
  localparam int unsigned DW = $clog2(MAX_DWELL) + 1;

  pll_state_e       state, state_nxt;
  logic [DW-1:0]    dwell;
  logic             lock_s;
  logic             retry_evt, loss_evt;
  logic [CNT_W-1:0] loss_cnt_nxt, retry_cnt_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // State, shared dwell counter and Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PLL_RST;
      dwell     <= '0;
      pll_reset <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pll_reset <= (state_nxt == PLL_RST);
      sys_rst   <= (state_nxt != RUN);
      ready     <= (state_nxt == RUN);
      if (state_nxt != state) begin
        dwell <= '0;
      end else if (dwell != '1) begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Next-state decode plus retry/loss events and status counter updates.
  always_comb begin
    state_nxt     = state;
    retry_evt     = 1'b0;
    loss_evt      = 1'b0;
    loss_cnt_nxt  = loss_cnt;
    retry_cnt_nxt = retry_cnt;

    case (state)
      PLL_RST: begin
        if (dwell == DW'(PLL_RST_CYCLES - 1)) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (dwell == DW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = PLL_RST;
          retry_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s)                               state_nxt = WAIT_LOCK;
        else if (dwell == DW'(STABLE_CYCLES - 1))  state_nxt = HOLD;
      end
      HOLD: begin
        if (!lock_s)                               state_nxt = WAIT_LOCK;
        else if (dwell == DW'(HOLD_CYCLES - 1))    state_nxt = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = PLL_RST;
          loss_evt  = 1'b1;
        end
      end
      default: state_nxt = PLL_RST;
    endcase

    // A same-cycle event beats the clear, leaving the counter at one.
    if (clr_status)                        loss_cnt_nxt = loss_evt ? CNT_W'(1) : '0;
    else if (loss_evt && loss_cnt != '1)   loss_cnt_nxt = loss_cnt + CNT_W'(1);

    if (clr_status)                        retry_cnt_nxt = retry_evt ? CNT_W'(1) : '0;
    else if (retry_evt && retry_cnt != '1) retry_cnt_nxt = retry_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_lost <= 1'b0;
      loss_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      lock_lost <= loss_evt | (lock_lost & ~clr_status);
      loss_cnt  <= loss_cnt_nxt;
      retry_cnt <= retry_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Scoreboard bench for pll_lock_seq: a deadline-based reference model predicts every
// cycle's outputs into a queue, and a negedge monitor compares the DUT against it.
module tb_pll_lock_seq;

  localparam int unsigned CW    = 3;
  localparam int          T_RST = 4;
  localparam int          T_TO  = 32;
  localparam int          T_ST  = 8;
  localparam int          T_HD  = 4;
  localparam int          SAT   = 7;

  localparam int M_RST  = 0;
  localparam int M_WAIT = 1;
  localparam int M_STAB = 2;
  localparam int M_HOLD = 3;
  localparam int M_RUN  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_lock = 1'b0;
  logic          clr_status = 1'b0;
  logic          pll_reset, sys_rst, ready, lock_lost;
  logic [CW-1:0] loss_cnt, retry_cnt;

  pll_lock_seq #(
    .PLL_RST_CYCLES (T_RST),
    .TIMEOUT_CYCLES (T_TO),
    .STABLE_CYCLES  (T_ST),
    .HOLD_CYCLES    (T_HD),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .clr_status (clr_status),
    .pll_reset  (pll_reset),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .loss_cnt   (loss_cnt),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  // Reference model: phase plus the edge it was entered on; each phase ends at a deadline.
  int n = 0;
  int ph = M_RST;
  int enter = 0;
  bit s1 = 1'b0, s2 = 1'b0, m_lost = 1'b0;
  int m_loss = 0, m_retry = 0;

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic model_step();
    bit lk, loss, retry;
    int nph, age;
    n++;
    if (rst) begin
      s1 = 1'b0; s2 = 1'b0; ph = M_RST; enter = n;
      m_lost = 1'b0; m_loss = 0; m_retry = 0;
    end else begin
      lk = s2; s2 = s1; s1 = pll_lock;
      age = n - enter;
      loss = 1'b0; retry = 1'b0; nph = ph;
      if (ph == M_RST && age == T_RST) nph = M_WAIT;
      else if (ph == M_WAIT) begin
        if (lk) nph = M_STAB;
        else if (age == T_TO) begin nph = M_RST; retry = 1'b1; end
      end else if (ph == M_STAB || ph == M_HOLD) begin
        if (!lk) nph = M_WAIT;
        else if (age == ((ph == M_STAB) ? T_ST : T_HD)) nph = ph + 1;
      end else if (ph == M_RUN && !lk) begin
        nph = M_RST; loss = 1'b1;
      end
      if (clr_status) begin
        m_loss = loss ? 1 : 0; m_retry = retry ? 1 : 0; m_lost = loss;
      end else begin
        if (loss) begin m_loss = sat_inc(m_loss); m_lost = 1'b1; end
        if (retry) m_retry = sat_inc(m_retry);
      end
      if (nph != ph) begin ph = nph; enter = n; end
    end
    exp_q.push_back({(ph == M_RST), (ph != M_RUN), (ph == M_RUN), m_lost,
                     3'(m_loss), 3'(m_retry)});
  endtask

  // One clock: the DUT and the model both consume the inputs currently driven.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_phase(input int p, input string name);
    int k;
    k = 0;
    while (ph != p && k < 500) begin tick(); k++; end
    checks++;
    if (ph != p) begin
      errors++;
      $display("FAIL %s: phase %0d not reached within 500 cycles (at %0d)", name, p, ph);
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {pll_reset, sys_rst, ready, lock_lost, loss_cnt, retry_cnt};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle_outputs edge %0d: got rst/sys/rdy/lost/loss/retry=%b expected %b",
                 n, g, e);
      end
    end
  end

  initial begin
    int lvl, dur;

    // Reset, then lock stuck low: pll_reset 4 high, 32 low, high again.
    rst = 1'b1; pll_lock = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      check("pll_reset_shape", int'(pll_reset), int'((i < 4) || (i >= 36 && i < 40)));
      check("ready_stuck_low", int'(ready), 0);
    end
    repeat (8 * 36) tick();
    check("retry_saturated", int'(retry_cnt), SAT);

    // Restart; lock rises at cycle 10 and stays: ready exactly 12 edges after edge E.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (9) tick();
    pll_lock = 1'b1;
    wait_phase(M_STAB, "first_lock");
    for (int i = 1; i <= T_ST + T_HD; i++) begin
      tick();
      check("ready_window", int'(ready), int'(i == T_ST + T_HD));
      check("sys_rst_window", int'(sys_rst), int'(i != T_ST + T_HD));
    end
    check("no_retry", int'(retry_cnt), 0);

    // Lose lock, relock, then glitch low for 3 cycles during STABLE.
    pll_lock = 1'b0; repeat (3) tick();
    pll_lock = 1'b1;
    wait_phase(M_STAB, "relock");
    tick(); tick();
    pll_lock = 1'b0; repeat (3) tick();
    pll_lock = 1'b1;
    wait_phase(M_STAB, "after_glitch");
    for (int i = 1; i <= T_ST + T_HD; i++) begin
      tick();
      check("ready_after_glitch", int'(ready), int'(i == T_ST + T_HD));
    end

    // Clear status, then drop lock in RUN: effect lands on the third edge.
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    check("clr_lock_lost", int'(lock_lost), 0);
    pll_lock = 1'b0;
    tick(); check("drop_edge1_ready", int'(ready), 1);
    tick(); check("drop_edge2_ready", int'(ready), 1);
    tick();
    check("drop_pll_reset", int'(pll_reset), 1);
    check("drop_sys_rst", int'(sys_rst), 1);
    check("drop_ready", int'(ready), 0);
    check("drop_lock_lost", int'(lock_lost), 1);
    check("drop_loss_cnt", int'(loss_cnt), 1);
    pll_lock = 1'b1;
    wait_phase(M_RUN, "relock_after_drop");
    tick();
    check("lost_sticky", int'(lock_lost), 1);
    check("ready_relocked", int'(ready), 1);

    // Build loss_cnt to 5, then clear in the same cycle as another loss.
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    repeat (5) begin
      pll_lock = 1'b0; repeat (3) tick();
      pll_lock = 1'b1;
      wait_phase(M_RUN, "loss_build");
    end
    check("loss_cnt_five", int'(loss_cnt), 5);
    pll_lock = 1'b0; tick(); tick();
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    check("clr_vs_loss_cnt", int'(loss_cnt), 1);
    check("clr_vs_loss_flag", int'(lock_lost), 1);
    check("clr_vs_loss_retry", int'(retry_cnt), 0);

    // rst pulsed during HOLD.
    pll_lock = 1'b1;
    wait_phase(M_HOLD, "reach_hold");
    tick();
    rst = 1'b1; tick();
    check("rst_hold_pll_reset", int'(pll_reset), 1);
    check("rst_hold_sys_rst", int'(sys_rst), 1);
    check("rst_hold_ready", int'(ready), 0);
    check("rst_hold_lock_lost", int'(lock_lost), 0);
    check("rst_hold_loss_cnt", int'(loss_cnt), 0);
    check("rst_hold_retry_cnt", int'(retry_cnt), 0);
    rst = 1'b0;

    // Random lock waveform with occasional clears and resets.
    for (int seg = 0; seg < 60; seg++) begin
      lvl = ($urandom_range(0, 3) != 0) ? 1 : 0;
      dur = lvl ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 8));
      pll_lock = lvl[0];
      for (int c = 0; c < dur; c++) begin
        clr_status = ($urandom_range(0, 15) == 0);
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    clr_status = 1'b0; rst = 1'b0;
    tick(); tick();
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
